// File: rtl/lsi_wbs_sram_if.sv
// Wishbone slave bus bundle for lsi_wbs_sram: master/slave views of the
// LSI-11 core master-bus cycle terminated by the on-chip SRAM responder.
interface lsi_wbs_sram_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic        wbs_ios_i;
    logic [15:0] wbs_adr_i;
    logic [1:0]  wbs_sel_i;
    logic [15:0] wbs_dat_i;
    logic [15:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ios_i,
        output wbs_adr_i, wbs_sel_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ios_i,
        input  wbs_adr_i, wbs_sel_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/lsi_wbs_sram.sv
// Wishbone slave SRAM responder (16-bit words, byte lanes, one ack per strobe).
// Define LSI_WBS_SRAM_WAIT_EN to build the WAIT state and honour WAITS.
//
//   state  | meaning
//   IDLE   | waiting for an in-range, non-I/O-page strobe
//   WAIT   | counting wait states; strobe drop aborts the cycle
//   ACK    | ack_o high for one cycle; access was done on the entry edge
//   HOLD   | waiting for strobe release so a stuck strobe is not re-acked
module lsi_wbs_sram #(
    parameter int unsigned AW    = 13,
    parameter int unsigned WAITS = 1
) (
    input  logic          vm_clk_p,
    input  logic          vm_rst_n,
    lsi_wbs_sram_if.slave wbs
);

`ifdef LSI_WBS_SRAM_WAIT_EN
    localparam int unsigned WAITS_EFF = WAITS;
    localparam logic [3:0]  WAIT_LOAD = 4'((WAITS > 0) ? WAITS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    logic [3:0] wait_cnt;
`else
    // Wait states are compiled out; WAITS is deliberately folded to zero.
    localparam int unsigned WAITS_EFF = WAITS & 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } state_t;
`endif

    state_t         state;
    logic           ack_q;
    logic [15:0]    dat_q;
    logic           hit;
    logic           go_ack;
    logic           mem_we;
    logic [AW-1:0]  widx;
    logic           unused_adr0;

    logic [15:0] mem [0:(2**AW)-1];

    assign widx        = wbs.wbs_adr_i[AW:1];
    assign unused_adr0 = wbs.wbs_adr_i[0];

    assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~wbs.wbs_ios_i
               & ((wbs.wbs_adr_i >> (AW + 1)) == 16'd0);

    // go_ack marks the edge that enters ACK: the access happens exactly there.
    always_comb begin
        go_ack = 1'b0;
        case (state)
            S_IDLE:  go_ack = hit && (WAITS_EFF == 0);
`ifdef LSI_WBS_SRAM_WAIT_EN
            S_WAIT:  go_ack = wbs.wbs_stb_i && (wait_cnt == 4'd0);
`endif
            default: go_ack = 1'b0;
        endcase
    end

    // Gated by reset so a pending write cannot land while the core is held.
    assign mem_we = go_ack & wbs.wbs_we_i & vm_rst_n;

    always_ff @(posedge vm_clk_p) begin
        if (mem_we) begin
            if (wbs.wbs_sel_i[0]) mem[widx][7:0]  <= wbs.wbs_dat_i[7:0];
            if (wbs.wbs_sel_i[1]) mem[widx][15:8] <= wbs.wbs_dat_i[15:8];
        end
    end

    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
            dat_q <= 16'd0;
`ifdef LSI_WBS_SRAM_WAIT_EN
            wait_cnt <= 4'd0;
`endif
        end else begin
            ack_q <= go_ack;
            if (go_ack && !wbs.wbs_we_i) dat_q <= mem[widx];
            case (state)
                S_IDLE: begin
                    if (go_ack) state <= S_ACK;
`ifdef LSI_WBS_SRAM_WAIT_EN
                    else if (hit) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
`endif
                end
`ifdef LSI_WBS_SRAM_WAIT_EN
                S_WAIT: begin
                    if (!wbs.wbs_stb_i)         state    <= S_IDLE;
                    else if (wait_cnt == 4'd0)  state    <= S_ACK;
                    else                        wait_cnt <= wait_cnt - 4'd1;
                end
`endif
                S_ACK:   state <= S_HOLD;
                S_HOLD:  if (!wbs.wbs_stb_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_lsi_wbs_sram.sv
// Directed self-checking bench for lsi_wbs_sram (AW=13, WAITS=2); expected
// latencies follow whether LSI_WBS_SRAM_WAIT_EN is defined for the build.
module tb_lsi_wbs_sram;
    localparam int TB_WAITS = 2;
`ifdef LSI_WBS_SRAM_WAIT_EN
    localparam int LAT = 1 + TB_WAITS;
`else
    localparam int LAT = 1;
`endif
    localparam int B2B = LAT + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;
    int   ack_count = 0;
    int   ack_cyc = 0;

    lsi_wbs_sram_if bus ();

    lsi_wbs_sram #(.AW(13), .WAITS(TB_WAITS)) dut (
        .vm_clk_p (clk),
        .vm_rst_n (rst_n),
        .wbs      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) if (bus.wbs_ack_o === 1'b1) ack_count++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_ios_i = 1'b0;
    endtask

    task automatic bus_req(input logic we, input logic ios, input logic [15:0] adr,
                           input logic [1:0] sel, input logic [15:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_ios_i = ios;
        bus.wbs_adr_i = adr;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = dat;
    endtask

    // One master cycle; lat = edges from request to ack (999 on timeout).
    task automatic xfer(input logic we, input logic [15:0] adr, input logic [1:0] sel,
                        input logic [15:0] dat, output int lat, output logic [15:0] rdat);
        lat  = 999;
        rdat = 16'h0;
        @(posedge clk); #1;
        bus_req(we, 1'b0, adr, sel, dat);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) begin
                lat     = n;
                rdat    = bus.wbs_dat_o;
                ack_cyc = cyc_cnt;
                break;
            end
        end
        bus_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        int          a0;
        int          c0;
        int          c1;
        logic [15:0] rd;

        bus_idle();
        bus.wbs_adr_i = 16'h0;
        bus.wbs_sel_i = 2'b00;
        bus.wbs_dat_i = 16'h0;

        // reset state
        #22;
        check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("rst_dat", {16'd0, bus.wbs_dat_o}, 32'd0);
        #6 rst_n = 1'b1;

        // seed a word, then abort a write to it with reset before its ACK edge
        xfer(1'b1, 16'o3000, 2'b11, 16'h5555, lat, rd);
        check("seed_wr_lat", lat, LAT);
        xfer(1'b0, 16'o3000, 2'b11, 16'h0, lat, rd);
        check("seed_rd_lat", lat, LAT);
        check("seed_rd_dat", {16'd0, rd}, 32'h5555);
        @(posedge clk); #1;
        bus_req(1'b1, 1'b0, 16'o3000, 2'b11, 16'hAAAA);
`ifdef LSI_WBS_SRAM_WAIT_EN
        @(posedge clk); #1;
`endif
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("midrst_dat", {16'd0, bus.wbs_dat_o}, 32'd0);
        bus_idle();
        @(posedge clk); #3 rst_n = 1'b1;
        xfer(1'b0, 16'o3000, 2'b11, 16'h0, lat, rd);
        check("midrst_keep", {16'd0, rd}, 32'h5555);

        // full word write/read
        xfer(1'b1, 16'o1000, 2'b11, 16'o123456, lat, rd);
        check("word_wr_lat", lat, LAT);
        xfer(1'b0, 16'o1000, 2'b11, 16'h0, lat, rd);
        check("word_rd_lat", lat, LAT);
        check("word_rd_dat", {16'd0, rd}, {16'd0, 16'o123456});

        // top word of the address space
        xfer(1'b1, 16'h3FFE, 2'b11, 16'hBEEF, lat, rd);
        xfer(1'b0, 16'h3FFE, 2'b01, 16'h0, lat, rd);
        check("top_rd_lat", lat, LAT);
        check("top_rd_dat", {16'd0, rd}, 32'hBEEF);

        // byte lanes
        xfer(1'b1, 16'o2000, 2'b11, 16'hFFFF, lat, rd);
        xfer(1'b1, 16'o2000, 2'b01, 16'h0012, lat, rd);
        xfer(1'b1, 16'o2000, 2'b10, 16'h3400, lat, rd);
        xfer(1'b0, 16'o2000, 2'b00, 16'h0, lat, rd);
        check("lane_rd_dat", {16'd0, rd}, 32'h3412);
        xfer(1'b1, 16'o2000, 2'b00, 16'h9999, lat, rd);
        check("sel00_ack_lat", lat, LAT);
        check("wr_holds_dat", {16'd0, bus.wbs_dat_o}, 32'h3412);
        xfer(1'b0, 16'o2000, 2'b11, 16'h0, lat, rd);
        check("sel00_unchanged", {16'd0, rd}, 32'h3412);

        // I/O page miss held for 100 cycles, then a normal read from IDLE
        a0 = ack_count;
        @(posedge clk); #1;
        bus_req(1'b0, 1'b1, 16'o177560, 2'b11, 16'h0);
        repeat (100) @(posedge clk);
        #1;
        check("ios_no_ack", ack_count - a0, 0);
        bus.wbs_adr_i = 16'o1000;
        repeat (20) @(posedge clk);
        #1;
        check("ios_inrange_no_ack", ack_count - a0, 0);
        bus_idle();
        xfer(1'b0, 16'o1000, 2'b11, 16'h0, lat, rd);
        check("after_ios_lat", lat, LAT);

        // out-of-range miss
        a0 = ack_count;
        xfer(1'b0, 16'o40000, 2'b11, 16'h0, lat, rd);
        check("oor_no_ack", ack_count - a0, 0);
        xfer(1'b0, 16'o2000, 2'b11, 16'h0, lat, rd);
        check("after_oor_lat", lat, LAT);
        check("after_oor_dat", {16'd0, rd}, 32'h3412);

        // strobe abort before ACK, then a fresh read
        a0 = ack_count;
        @(posedge clk); #1;
        bus_req(1'b1, 1'b0, 16'o1000, 2'b11, 16'h0BAD);
`ifdef LSI_WBS_SRAM_WAIT_EN
        @(posedge clk); #1;
`endif
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        xfer(1'b0, 16'o1000, 2'b11, 16'h0, lat, rd);
        check("abort_one_ack", ack_count - a0, 1);
        check("abort_rd_dat", {16'd0, rd}, {16'd0, 16'o123456});

        // stuck strobe: hold 5 cycles past ack
        a0 = ack_count;
        lat = 999;
        @(posedge clk); #1;
        bus_req(1'b0, 1'b0, 16'o3000, 2'b11, 16'h0);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        check("stuck_lat", lat, LAT);
        check("stuck_one_ack", ack_count - a0, 1);

        // back-to-back reads
        xfer(1'b0, 16'o1000, 2'b11, 16'h0, lat, rd);
        c0 = ack_cyc;
        xfer(1'b0, 16'o2000, 2'b11, 16'h0, lat, rd);
        c1 = ack_cyc;
        check("b2b_period_1", c1 - c0, B2B);
        check("b2b_dat_1", {16'd0, rd}, 32'h3412);
        xfer(1'b0, 16'o3000, 2'b11, 16'h0, lat, rd);
        check("b2b_period_2", ack_cyc - c1, B2B);
        check("b2b_dat_2", {16'd0, rd}, 32'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
